cpu_mem_responder: RTL and testbench
====================================

Name: cpu_mem_responder

Overview:
Bus-side responder for the Cpu read/write request interface: a byte-wide RAM that answers req_rdwr/which_rdwr/addr/data_out from the core. It inserts a configurable number of wait states, returns read data, and drives the core's enable input as a stall signal. It is the first memory model and bus target in the system and sits between the Cpu and future address decoding.

Parameters:
ADDR_WIDTH, 16, address bus width; matches the core's 16-bit absolute address.
DATA_WIDTH, 8, data bus width.
MEM_DEPTH, 4096, implemented bytes; power of two, at most 2**ADDR_WIDTH.
WAIT_CYCLES, 1, wait states inserted before each access completes (0..15).
ROM_BASE, 16'h0F00, first write-protected address; used only with the optional feature.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
req_rdwr  in  1  core requests an access; held with addr/which_rdwr/wr_data until ack
which_rdwr  in  1  0 = read (ENUM__CPU_WH_RDWR__READ), 1 = write (ENUM__CPU_WH_RDWR__WRITE)
addr  in  ADDR_WIDTH  access address
wr_data  in  DATA_WIDTH  write data (core data_out)
rd_data  out  DATA_WIDTH  read data (to core data_in)
ready  out  1  drives core enable; 0 stalls the core
ack  out  1  one-cycle pulse: access complete, rd_data valid for reads
err  out  1  one-cycle pulse with ack: the access failed (out of range or protected)

Behaviour:
- Reset (rst low, asynchronous): state IDLE, ready=1, ack=0, err=0, rd_data=8'h00, wait counter=0, latched request cleared. RAM contents are not reset. Reset mid-transaction aborts it, and a pending write is not performed.
- States: IDLE, WAIT, ACCESS, ACK.
- IDLE: when req_rdwr=1 at a clock edge, the block latches addr, which_rdwr and wr_data and sets ready<=0. It goes to WAIT with counter<=WAIT_CYCLES, or directly to ACCESS when WAIT_CYCLES=0.
- WAIT: the counter decrements each cycle and the block moves to ACCESS on the edge where the counter is 1. ready stays 0. req_rdwr is ignored, and deasserting it does not cancel the latched access.
- ACCESS (one cycle):
  - In range (latched addr < MEM_DEPTH): a write stores wr_data; a read loads rd_data from RAM.
  - Out of range: a write is dropped; a read returns rd_data=8'hFF (open bus); err<=1.
  - In all cases ack<=1, ready<=1, and the next state is ACK.
- ACK: ack and err are high for exactly this cycle. req_rdwr is ignored here, so a held request is not re-accepted. Next state is IDLE, where ack and err drop to 0.
- Latency: a request sampled at edge N produces ack high after edge N+WAIT_CYCLES+1. Minimum issue interval is WAIT_CYCLES+3 cycles.
- rd_data holds its value until the next read completes; writes do not change it.
- RAM is indexed with addr[log2(MEM_DEPTH)-1:0] only when in range; there is no wrap-around aliasing.
- A read following a write to the same address returns the newly written value.

Optional Feature:
CPU_MEM_ROM_PROTECT_EN
- Defined: in-range addresses >= ROM_BASE are read-only. A write there leaves the RAM unchanged and completes with the normal ack and err=1. Reads there behave normally.
- Undefined: all in-range addresses are writable; ROM_BASE is ignored.

Test Plan:
- Reset: hold rst=0 and toggle inputs -> ready=1, ack=0, err=0, rd_data=8'h00. Assert rst=0 during WAIT -> immediate IDLE/ready=1, and the write to 16'h0010 is not performed.
- Write/read, WAIT_CYCLES=1: write 8'hA5 to 16'h0010, then read 16'h0010 -> each ack arrives 2 edges after acceptance, ready=0 in between, rd_data=8'hA5, err=0.
- Held request: keep req_rdwr=1 through ack -> exactly one ack per accepted request, re-accepted only after ACK->IDLE (period 4 cycles at WAIT_CYCLES=1).
- Out of range, MEM_DEPTH=4096: read 16'h2000 -> rd_data=8'hFF, ack=1, err=1. Write 8'h11 to 16'h1000, then read 16'h0000 -> value unchanged (no aliasing).
- WAIT_CYCLES=0 and WAIT_CYCLES=3: ack arrives 1 and 4 edges after acceptance respectively. Dropping req_rdwr during WAIT still completes the access.
- CPU_MEM_ROM_PROTECT_EN defined: write 8'h5A to 16'h0F00 -> err=1, and a read of 16'h0F00 returns the prior value. A write to 16'h0EFF succeeds with err=0.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//   Bus-side responder for the Cpu read/write request interface. This block
//   is a byte-wide RAM that inserts WAIT_CYCLES wait states per access,
//   returns read data, and drives the core's enable input as a stall signal.
//
//   Configuration macro: CPU_MEM_ROM_PROTECT_EN
//     defined   - in-range addresses >= ROM_BASE are read-only; a write there
//                 is dropped and completes with err=1
//     undefined - every in-range address is writable, ROM_BASE is ignored
//
//   Ports
//     clk         in   system clock, rising edge
//     rst         in   asynchronous active-low reset
//     req_rdwr    in   access request; held with addr/which_rdwr/wr_data until ack
//     which_rdwr  in   0 = read, 1 = write
//     addr        in   access address (ADDR_WIDTH)
//     wr_data     in   write data (DATA_WIDTH)
//     rd_data     out  read data, holds until the next read completes
//     ready       out  core enable; 0 stalls the core
//     ack         out  one-cycle completion pulse
//     err         out  one-cycle pulse with ack: out of range or protected
module cpu_mem_responder #(
  parameter int unsigned            ADDR_WIDTH  = 16,
  parameter int unsigned            DATA_WIDTH  = 8,
  parameter int unsigned            MEM_DEPTH   = 4096,
  parameter int unsigned            WAIT_CYCLES = 1,
  parameter logic [ADDR_WIDTH-1:0]  ROM_BASE    = ADDR_WIDTH'(16'h0F00)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_rdwr,
  input  logic                  which_rdwr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ready,
  output logic                  ack,
  output logic                  err
);

  localparam int unsigned           IDX_W     = $clog2(MEM_DEPTH);
  // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [3:0]            WAIT_INIT = 4'(WAIT_CYCLES);

`ifdef CPU_MEM_ROM_PROTECT_EN
  localparam logic                  PROTECT   = 1'b1;
`else
  localparam logic                  PROTECT   = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_ACK
  } state_t;

  state_t                  state, state_d;
  logic [3:0]              cnt, cnt_d;
  logic                    ready_d, ack_d, err_d;
  logic [DATA_WIDTH-1:0]   rd_data_d;

  // Request captured at acceptance; the core may change its inputs afterwards.
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic                    lat_we;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic                    latch_en;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [IDX_W-1:0]        mem_idx;
  logic                    mem_we;
  logic                    in_range;
  logic                    rom_hit;

  // No aliasing: the truncated index is only used when the full address is
  // below MEM_DEPTH.
  assign in_range = ({1'b0, lat_addr} < DEPTH_LIM);
  assign mem_idx  = lat_addr[IDX_W-1:0];
  assign rom_hit  = PROTECT && (lat_addr >= ROM_BASE);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    ready_d   = ready;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rd_data_d = rd_data;
    latch_en  = 1'b0;
    mem_we    = 1'b0;

    unique case (state)
      S_IDLE: begin
        ready_d = 1'b1;
        if (req_rdwr) begin
          latch_en = 1'b1;
          ready_d  = 1'b0;
          cnt_d    = WAIT_INIT;
          state_d  = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end

      S_WAIT: begin
        // req_rdwr is not looked at: the latched access always completes.
        cnt_d = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        ack_d   = 1'b1;
        ready_d = 1'b1;
        state_d = S_ACK;
        if (in_range) begin
          if (lat_we) begin
            if (rom_hit) begin
              err_d = 1'b1;
            end else begin
              mem_we = 1'b1;
            end
          end else begin
            rd_data_d = mem[mem_idx];
          end
        end else begin
          err_d = 1'b1;
          if (!lat_we) begin
            rd_data_d = '1;
          end
        end
      end

      S_ACK: begin
        // A still-held request is only re-sampled once back in IDLE.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ready     <= 1'b1;
      ack       <= 1'b0;
      err       <= 1'b0;
      rd_data   <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      ready   <= ready_d;
      ack     <= ack_d;
      err     <= err_d;
      rd_data <= rd_data_d;
      if (latch_en) begin
        lat_addr  <= addr;
        lat_we    <= which_rdwr;
        lat_wdata <= wr_data;
      end
    end
  end

  // RAM contents survive reset. A reset before ACCESS leaves state in IDLE,
  // so an aborted write never reaches this port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= lat_wdata;
    end
  end

  // Protocol invariants of the response side.
  a_ack_one_cycle: assert property (@(posedge clk) disable iff (!rst)
    ack |=> !ack);
  a_err_with_ack: assert property (@(posedge clk) disable iff (!rst)
    err |-> ack);
  a_ack_ready: assert property (@(posedge clk) disable iff (!rst)
    ack |-> ready);

endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;

  // Three responders with different wait-state counts share clock and reset.
  localparam int unsigned NDUT = 3;

  logic        clk;
  logic        rst;
  logic        req     [NDUT];
  logic        we      [NDUT];
  logic [15:0] addr    [NDUT];
  logic [7:0]  wdata   [NDUT];
  logic [7:0]  rd_data [NDUT];
  logic        ready   [NDUT];
  logic        ack     [NDUT];
  logic        err     [NDUT];

  int vectors     = 0;
  int miscompares = 0;

  cpu_mem_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req_rdwr(req[0]), .which_rdwr(we[0]),
    .addr(addr[0]), .wr_data(wdata[0]), .rd_data(rd_data[0]),
    .ready(ready[0]), .ack(ack[0]), .err(err[0]));

  cpu_mem_responder #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .req_rdwr(req[1]), .which_rdwr(we[1]),
    .addr(addr[1]), .wr_data(wdata[1]), .rd_data(rd_data[1]),
    .ready(ready[1]), .ack(ack[1]), .err(err[1]));

  cpu_mem_responder #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .req_rdwr(req[2]), .which_rdwr(we[2]),
    .addr(addr[2]), .wr_data(wdata[2]), .rd_data(rd_data[2]),
    .ready(ready[2]), .ack(ack[2]), .err(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: byte array per responder plus a "known" flag so that
  // never-written RAM (not reset) is not compared.
  logic [7:0] mm     [NDUT][4096];
  bit         kn     [NDUT][4096];
  logic [7:0] mrd    [NDUT];
  bit         mrd_kn [NDUT];

`ifdef CPU_MEM_ROM_PROTECT_EN
  localparam bit ROM_ON = 1'b1;
`else
  localparam bit ROM_ON = 1'b0;
`endif

  function automatic int wait_of(input int d);
    case (d)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag, input int d,
                     input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  // One complete transaction. Inputs are scrambled right after acceptance
  // to prove the latched copy is used and that dropping req cancels nothing.
  task automatic do_access(input int d, input bit w,
                           input logic [15:0] a, input logic [7:0] wd);
    int  lat;
    bit  got;
    bit  rng;
    bit  exp_err;
    rng     = (a < 16'd4096);
    exp_err = !rng || (w && ROM_ON && a >= 16'h0F00);

    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    @(posedge clk); #1;
    chk("accept_ready", d, ready[d], 1'b0);
    req[d] = 1'b0; we[d] = 1'($urandom); addr[d] = 16'($urandom);
    wdata[d] = 8'($urandom);

    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ack[d] === 1'b1) got = 1'b1;
      else chk("stall_ready", d, ready[d], 1'b0);
    end
    chk("latency", d, lat, wait_of(d) + 1);

    // Model update
    if (w) begin
      if (rng && !exp_err) begin
        mm[d][a[11:0]] = wd;
        kn[d][a[11:0]] = 1'b1;
      end
    end else if (rng) begin
      mrd[d]    = mm[d][a[11:0]];
      mrd_kn[d] = kn[d][a[11:0]];
    end else begin
      mrd[d]    = 8'hFF;
      mrd_kn[d] = 1'b1;
    end

    chk("ack_err", d, err[d], exp_err);
    chk("ack_ready", d, ready[d], 1'b1);
    if (mrd_kn[d]) chk("rd_data", d, rd_data[d], mrd[d]);

    @(posedge clk); #1;
    chk("ack_drop", d, ack[d], 1'b0);
    chk("err_drop", d, err[d], 1'b0);
  endtask

  initial begin
    logic [7:0]  prior;
    logic [15:0] ra;
    bit          rw;

    for (int d = 0; d < NDUT; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      mrd[d] = 8'h00; mrd_kn[d] = 1'b1;
      for (int i = 0; i < 4096; i++) kn[d][i] = 1'b0;
    end
    rst = 1'b0;

    // Reset held with inputs toggling
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        req[d] = 1'($urandom); we[d] = 1'($urandom);
        addr[d] = 16'($urandom_range(0, 31)); wdata[d] = 8'($urandom);
      end
      @(posedge clk); #1;
      for (int d = 0; d < NDUT; d++) begin
        chk("rst_ready", d, ready[d], 1'b1);
        chk("rst_ack", d, ack[d], 1'b0);
        chk("rst_err", d, err[d], 1'b0);
        chk("rst_rd_data", d, rd_data[d], 8'h00);
      end
    end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) req[d] = 1'b0;
    rst = 1'b1;

    // Basic write/read at one wait state
    do_access(1, 1'b1, 16'h0010, 8'hA5);
    do_access(1, 1'b0, 16'h0010, 8'h00);

    // Out of range and no aliasing
    do_access(1, 1'b1, 16'h0000, 8'h3C);
    do_access(1, 1'b0, 16'h2000, 8'h00);
    do_access(1, 1'b1, 16'h1000, 8'h11);
    do_access(1, 1'b0, 16'h0000, 8'h00);
    do_access(1, 1'b0, 16'hFFFF, 8'h00);
    do_access(1, 1'b0, 16'h0FFF, 8'h00);

    // Held request: one ack per accepted request, period WAIT_CYCLES+3
    do_access(1, 1'b0, 16'h0010, 8'h00);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0010;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      chk("held_ack", 1, ack[1],
          (e >= 3) && ((e - 3) % 4 == 0));
      chk("held_rd", 1, rd_data[1], 8'hA5);
    end
    @(negedge clk);
    req[1] = 1'b0;
    @(posedge clk); #1;
    chk("held_release_ready", 1, ready[1], 1'b1);

    // Reset during WAIT aborts a pending write
    do_access(2, 1'b1, 16'h0010, 8'h3C);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0010; wdata[2] = 8'h77;
    @(posedge clk); #1;
    req[2] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midrst_ready", 2, ready[2], 1'b1);
    chk("midrst_ack", 2, ack[2], 1'b0);
    chk("midrst_rd", 2, rd_data[2], 8'h00);
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      mrd[d] = 8'h00; mrd_kn[d] = 1'b1;
    end
    @(posedge clk); #1;
    chk("postrst_ack", 2, ack[2], 1'b0);
    do_access(2, 1'b0, 16'h0010, 8'h00);

    // Zero and three wait states
    do_access(0, 1'b1, 16'h0020, 8'hC3);
    do_access(0, 1'b0, 16'h0020, 8'h00);
    do_access(0, 1'b0, 16'h4000, 8'h00);
    do_access(2, 1'b1, 16'h0021, 8'h5E);
    do_access(2, 1'b0, 16'h0021, 8'h00);
    do_access(2, 1'b1, 16'h1234, 8'h99);

    // Protected region boundary
    do_access(1, 1'b1, 16'h0EFF, 8'h66);
    do_access(1, 1'b0, 16'h0EFF, 8'h00);
    do_access(1, 1'b0, 16'h0F00, 8'h00);
    prior = rd_data[1];
    do_access(1, 1'b1, 16'h0F00, 8'h5A);
    do_access(1, 1'b0, 16'h0F00, 8'h00);
`ifdef CPU_MEM_ROM_PROTECT_EN
    chk("rom_unchanged", 1, rd_data[1], prior);
`endif

    // Randomized traffic against the model
    for (int d = 0; d < NDUT; d++) begin
      for (int n = 0; n < 30; n++) begin
        case ($urandom_range(0, 3))
          0:       ra = 16'($urandom_range(16'h1000, 16'hFFFF));
          1:       ra = 16'($urandom_range(16'h0EF8, 16'h0F07));
          default: ra = 16'($urandom_range(0, 15));
        endcase
        rw = 1'($urandom);
        do_access(d, rw, ra, 8'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
